line_mem_arbiter: RTL and testbench
===================================

# line_mem_arbiter

Arbitrates the instruction-cache and data-cache line requests onto the single physical-memory port. It also converts between 256-bit cache lines and the 4-beat × 64-bit burst protocol of physical memory. It sits below both caches and generates the `icache_pmem_resp` / `dcache_pmem_resp` responses that ultimately become the pipeline's `inst_resp` / `data_resp` stall inputs. It serves one transaction at a time, with data-side priority.

## Interface
Parameters:
- `BURST_LEN`, default 4: beats per line.
- `BEAT_W`, default 64: bits per beat.
- `LINE_W`, default `BURST_LEN*BEAT_W` (256): line width.

Ports (clock and reset first):
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `icache_pmem_read`  in  1  I-cache line read request; held until resp.
- `icache_pmem_address`  in  32  I-cache line address.
- `icache_pmem_rdata`  out  LINE_W  line returned to I-cache.
- `icache_pmem_resp`  out  1  one-cycle completion pulse to I-cache.
- `dcache_pmem_read`  in  1  D-cache line read request; held until resp.
- `dcache_pmem_write`  in  1  D-cache line writeback request; held until resp.
- `dcache_pmem_address`  in  32  D-cache line address.
- `dcache_pmem_wdata`  in  LINE_W  writeback line.
- `dcache_pmem_rdata`  out  LINE_W  line returned to D-cache.
- `dcache_pmem_resp`  out  1  one-cycle completion pulse to D-cache.
- `pmem_read`  out  1  burst read request to memory.
- `pmem_write`  out  1  burst write request to memory.
- `pmem_address`  out  32  line-aligned burst address.
- `pmem_rdata`  in  BEAT_W  read beat; valid when `pmem_resp`=1.
- `pmem_wdata`  out  BEAT_W  write beat for current beat index.
- `pmem_resp`  in  1  one beat accepted or delivered this cycle.

## Operation
- **States:** IDLE, I_READ, D_READ, D_WRITE, I_DONE, D_DONE. All memory-side strobes and both resp outputs are Moore outputs decoded from the state register.
- **IDLE arbitration** (first match wins):
  - `dcache_pmem_write` → D_WRITE.
  - `dcache_pmem_read` → D_READ.
  - `icache_pmem_read` → I_READ.
- **On accept:**
  - Latch the address with bits [4:0] forced to 0.
  - For a write, latch `dcache_pmem_wdata`.
  - Clear the beat counter (`$clog2(BURST_LEN)` bits).
  - Requester inputs are ignored until the transaction ends.
- **Read states:**
  - `pmem_read`=1.
  - Each cycle with `pmem_resp`=1, store `pmem_rdata` into line buffer bits [BEAT_W*k +: BEAT_W] (k = counter), then increment the counter.
  - On the beat with k = BURST_LEN−1, go to I_DONE or D_DONE.
- **Write state:**
  - `pmem_write`=1; `pmem_wdata` = latched line[BEAT_W*k +: BEAT_W].
  - Advance k on `pmem_resp`; after the last beat go to D_DONE.
- **DONE states:**
  - Assert the matching `*_pmem_resp` for exactly one cycle, with both memory strobes low.
  - Then return to IDLE.
- **rdata outputs:** `icache_pmem_rdata` and `dcache_pmem_rdata` are separate registers. Each is updated only by its own read transactions and holds its value until that side's next read completes.
- **Ignored / illegal inputs:**
  - `pmem_resp` in IDLE or DONE is ignored.
  - `dcache_pmem_read` and `dcache_pmem_write` asserted together is treated as a write.
- **Reset:**
  - State IDLE, counter 0, all strobes, resps and rdata registers 0.
  - Reset mid-burst aborts the transaction: strobes are low in the cycle after reset and no resp is issued. Requesters reissue.

## Timing
- Request visible in IDLE at cycle 0; strobe high from cycle 1.
- With memory returning beats on cycles 1–4, resp is high in cycle 5. Minimum request-to-resp latency is 5 cycles; each memory stall cycle adds one.
- `pmem_address` is stable and strobes are held continuously from cycle 1 through the final beat.
- Strobes are low for at least one cycle (the DONE state) between consecutive bursts.
- The requester deasserts its request in the cycle after resp. An IDLE cycle always follows DONE, so a dropped request is never re-served.
- **Starvation:** a request arriving while the other side is served waits. I-side can wait behind back-to-back D-side transactions, by design; the pipeline is stalled on data in that case anyway.

## Test plan
- **I-read, zero-wait memory:**
  - Stimulus: `icache_pmem_read`=1, address 0x0000_1234; beats 0x11…, 0x22…, 0x33…, 0x44… on cycles 1–4.
  - Required: `pmem_address`=0x0000_1220; `icache_pmem_resp` high only in cycle 5; `icache_pmem_rdata` = {0x44…, 0x33…, 0x22…, 0x11…}; `dcache_pmem_rdata` unchanged.
- **D-write with stalls:**
  - Stimulus: writeback of line 0xAAAA…_BBBB…_CCCC…_DDDD… to 0x8000_0040; `pmem_resp` only every other cycle.
  - Required: `pmem_wdata` = 0xDDDD…, 0xCCCC…, 0xBBBB…, 0xAAAA… in beat order; `pmem_write` held for 8 cycles; resp in cycle 9.
- **Simultaneous requests:**
  - Stimulus: I-read and D-read both asserted in the same IDLE cycle.
  - Required: D served first and its resp seen; I starts after the IDLE cycle; total of two bursts with strobes low between them.
- **Writeback then refill:**
  - Stimulus: D-write followed by a D-read on the cycle after resp.
  - Required: two separate bursts, each with the correct address; strobe gap ≥1 cycle.
- **Reset mid-burst:**
  - Stimulus: assert `rst` after beat 2 of an I-read.
  - Required: strobes low next cycle; no `icache_pmem_resp`; `icache_pmem_rdata`=0; a reissued request completes normally.
- **Spurious `pmem_resp` in IDLE:**
  - Stimulus: `pmem_resp` pulsed while no request is pending.
  - Required: no state change; no resp; counter stays 0.

Source files
------------

// File: rtl/line_mem_arbiter.sv
// Serves one I-cache or D-cache line transfer at a time on the burst memory port; D-side wins in IDLE.
// Response arrives 5 cycles after the request plus one per memory stall; requesters hold their request until resp.
module line_mem_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int BEAT_W    = 64,
  parameter int LINE_W    = BURST_LEN*BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_pmem_read,
  input  logic [31:0]       icache_pmem_address,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,
  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [31:0]       dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  input  logic [BEAT_W-1:0] pmem_rdata,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic              pmem_resp
);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN-1);
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFE0;

  typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, I_DONE, D_DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [31:0]       addr;
  logic [LINE_W-1:0] line;
  logic [LINE_W-1:0] fill;

  // Line buffer with the incoming beat merged in, so the last beat lands in rdata on the same edge.
  always_comb begin
    fill = line;
    fill[BEAT_W*cnt +: BEAT_W] = pmem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      addr              <= '0;
      line              <= '0;
      icache_pmem_rdata <= '0;
      dcache_pmem_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dcache_pmem_write) begin
            state <= D_WRITE;
            addr  <= dcache_pmem_address & ADDR_MASK;
            line  <= dcache_pmem_wdata;
          end else if (dcache_pmem_read) begin
            state <= D_READ;
            addr  <= dcache_pmem_address & ADDR_MASK;
          end else if (icache_pmem_read) begin
            state <= I_READ;
            addr  <= icache_pmem_address & ADDR_MASK;
          end
        end
        I_READ, D_READ: begin
          if (pmem_resp) begin
            line <= fill;
            cnt  <= cnt + CW'(1);
            if (cnt == LAST) begin
              if (state == I_READ) begin
                icache_pmem_rdata <= fill;
                state             <= I_DONE;
              end else begin
                dcache_pmem_rdata <= fill;
                state             <= D_DONE;
              end
            end
          end
        end
        D_WRITE: begin
          if (pmem_resp) begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= D_DONE;
          end
        end
        I_DONE, D_DONE: state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

  assign pmem_read        = (state == I_READ) || (state == D_READ);
  assign pmem_write       = (state == D_WRITE);
  assign icache_pmem_resp = (state == I_DONE);
  assign dcache_pmem_resp = (state == D_DONE);
  assign pmem_address     = addr;
  assign pmem_wdata       = line[BEAT_W*cnt +: BEAT_W];

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed bench: stimulus pushes expected bursts, write beats and responses; a negedge monitor pops and compares.
module tb_line_mem_arbiter;
  logic         clk;
  logic         rst;
  logic         icache_pmem_read;
  logic [31:0]  icache_pmem_address;
  logic [255:0] icache_pmem_rdata;
  logic         icache_pmem_resp;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [31:0]  dcache_pmem_address;
  logic [255:0] dcache_pmem_wdata;
  logic [255:0] dcache_pmem_rdata;
  logic         dcache_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_rdata;
  logic [63:0]  pmem_wdata;
  logic         pmem_resp;

  line_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
    .icache_pmem_rdata(icache_pmem_rdata), .icache_pmem_resp(icache_pmem_resp),
    .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
    .dcache_pmem_rdata(dcache_pmem_rdata), .dcache_pmem_resp(dcache_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp)
  );

  typedef struct { bit side; logic [255:0] ri; logic [255:0] rd; int cyc; } resp_t;
  typedef struct { bit wr; logic [31:0] addr; int cyc; } burst_t;

  resp_t       rq[$];
  burst_t      bq[$];
  logic [63:0] wq[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int to_err;
  bit done, stall_mode, spurious, idle_probe;
  logic [255:0] exp_i, exp_d;
  logic [63:0]  rbeat [4];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: answers while a strobe is high, optionally only every other cycle.
  initial begin : mem_model
    bit [1:0] bi;
    bit ph;
    bi = 0; ph = 0;
    pmem_resp = 0; pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (pmem_read || pmem_write) begin
        if (!stall_mode || ph) begin
          pmem_resp  = 1;
          pmem_rdata = pmem_read ? rbeat[bi] : 64'h0;
          bi = bi + 2'd1;
        end else begin
          pmem_resp  = 0;
          pmem_rdata = 64'h0;
        end
        ph = !ph;
      end else begin
        pmem_resp  = spurious;
        pmem_rdata = spurious ? 64'hDEAD_BEEF_DEAD_BEEF : 64'h0;
        bi = 0; ph = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    bit prev_s, s;
    logic [31:0] cur_addr;
    resp_t r;
    burst_t b;
    prev_s = 0; cur_addr = '0;
    forever begin
      @(negedge clk);
      if (done || cyc > 3000) begin
        if (!done) begin
          n_cmp++; n_fail++;
          $display("FAIL watchdog actual=%0d required<=3000", cyc);
        end
        chk("resp_queue_left", 256'(rq.size()), 256'd0);
        chk("burst_queue_left", 256'(bq.size()), 256'd0);
        chk("wbeat_queue_left", 256'(wq.size()), 256'd0);
        chk("resp_timeouts", 256'(to_err), 256'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
      if (!rst) begin
        s = pmem_read | pmem_write;
        if (s && !prev_s) begin
          if (bq.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL burst_unexpected actual=1 required=0 at cycle %0d", cyc);
          end else begin
            b = bq.pop_front();
            cur_addr = b.addr;
            chk("burst_is_write", 256'(pmem_write), 256'(b.wr));
            chk("burst_address", 256'(pmem_address), 256'(b.addr));
            chk("burst_start_cycle", 256'(cyc), 256'(b.cyc));
          end
        end else if (s) begin
          chk("address_stable", 256'(pmem_address), 256'(cur_addr));
        end
        if (pmem_write && pmem_resp) begin
          if (wq.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL wbeat_unexpected actual=%h required=none", pmem_wdata);
          end else begin
            chk("write_beat", 256'(pmem_wdata), 256'(wq.pop_front()));
          end
        end
        if (icache_pmem_resp || dcache_pmem_resp) begin
          if (rq.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL resp_unexpected actual=1 required=0 at cycle %0d", cyc);
          end else begin
            r = rq.pop_front();
            chk("resp_side_d", 256'(dcache_pmem_resp), 256'(r.side));
            chk("resp_side_i", 256'(icache_pmem_resp), 256'(!r.side));
            chk("resp_cycle", 256'(cyc), 256'(r.cyc));
            chk("resp_strobes_low", 256'(s), 256'd0);
            chk("resp_icache_rdata", icache_pmem_rdata, r.ri);
            chk("resp_dcache_rdata", dcache_pmem_rdata, r.rd);
          end
        end
        if (idle_probe) begin
          chk("idle_pmem_read", 256'(pmem_read), 256'd0);
          chk("idle_pmem_write", 256'(pmem_write), 256'd0);
          chk("idle_icache_resp", 256'(icache_pmem_resp), 256'd0);
          chk("idle_dcache_resp", 256'(dcache_pmem_resp), 256'd0);
          chk("idle_icache_rdata", icache_pmem_rdata, exp_i);
          chk("idle_dcache_rdata", dcache_pmem_rdata, exp_d);
        end
        prev_s = s;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(input bit side);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (side ? dcache_pmem_resp : icache_pmem_resp) break;
      n++;
    end
    if (n >= 40) to_err++;
    tick();
  endtask

  initial begin : stim
    int t0;
    rst = 1; done = 0; to_err = 0; stall_mode = 0; spurious = 0; idle_probe = 0;
    icache_pmem_read = 0; icache_pmem_address = '0;
    dcache_pmem_read = 0; dcache_pmem_write = 0; dcache_pmem_address = '0; dcache_pmem_wdata = '0;
    exp_i = '0; exp_d = '0;
    rbeat = '{64'h0, 64'h0, 64'h0, 64'h0};
    repeat (3) tick();
    rst = 0;
    idle_probe = 1; tick(); idle_probe = 0;

    // I-read, zero-wait memory
    rbeat = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    t0 = cyc;
    icache_pmem_read = 1; icache_pmem_address = 32'h0000_1234;
    bq.push_back('{1'b0, 32'h0000_1220, t0 + 1});
    exp_i = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    rq.push_back('{1'b0, exp_i, exp_d, t0 + 5});
    wait_resp(0);
    icache_pmem_read = 0;

    // D-write with a stall every other cycle
    stall_mode = 1; tick();
    t0 = cyc;
    dcache_pmem_write = 1; dcache_pmem_address = 32'h8000_0040;
    dcache_pmem_wdata = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                         64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    wq.push_back(64'hDDDD_DDDD_DDDD_DDDD); wq.push_back(64'hCCCC_CCCC_CCCC_CCCC);
    wq.push_back(64'hBBBB_BBBB_BBBB_BBBB); wq.push_back(64'hAAAA_AAAA_AAAA_AAAA);
    bq.push_back('{1'b1, 32'h8000_0040, t0 + 1});
    rq.push_back('{1'b1, exp_i, exp_d, t0 + 9});
    wait_resp(1);
    dcache_pmem_write = 0; stall_mode = 0;
    tick();

    // Simultaneous I-read and D-read: D first, I after the IDLE cycle
    rbeat = '{64'h5555_0000_0000_0000, 64'h5555_0000_0000_0001,
              64'h5555_0000_0000_0002, 64'h5555_0000_0000_0003};
    t0 = cyc;
    dcache_pmem_read = 1; dcache_pmem_address = 32'h0000_201F;
    icache_pmem_read = 1; icache_pmem_address = 32'h0000_3008;
    bq.push_back('{1'b0, 32'h0000_2000, t0 + 1});
    exp_d = {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
             64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};
    rq.push_back('{1'b1, exp_i, exp_d, t0 + 5});
    bq.push_back('{1'b0, 32'h0000_3000, t0 + 7});
    exp_i = {64'h6666_0000_0000_0003, 64'h6666_0000_0000_0002,
             64'h6666_0000_0000_0001, 64'h6666_0000_0000_0000};
    rq.push_back('{1'b0, exp_i, exp_d, t0 + 11});
    wait_resp(1);
    dcache_pmem_read = 0;
    rbeat = '{64'h6666_0000_0000_0000, 64'h6666_0000_0000_0001,
              64'h6666_0000_0000_0002, 64'h6666_0000_0000_0003};
    wait_resp(0);
    icache_pmem_read = 0;
    tick();

    // Writeback then refill on the cycle after resp
    t0 = cyc;
    dcache_pmem_write = 1; dcache_pmem_address = 32'h0000_4010;
    dcache_pmem_wdata = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                         64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    wq.push_back(64'hA0A0_A0A0_A0A0_A0A0); wq.push_back(64'hA1A1_A1A1_A1A1_A1A1);
    wq.push_back(64'hA2A2_A2A2_A2A2_A2A2); wq.push_back(64'hA3A3_A3A3_A3A3_A3A3);
    bq.push_back('{1'b1, 32'h0000_4000, t0 + 1});
    rq.push_back('{1'b1, exp_i, exp_d, t0 + 5});
    rbeat = '{64'h7777_0000_0000_0000, 64'h7777_0000_0000_0001,
              64'h7777_0000_0000_0002, 64'h7777_0000_0000_0003};
    wait_resp(1);
    t0 = cyc;
    dcache_pmem_write = 0; dcache_pmem_read = 1; dcache_pmem_address = 32'h0000_5000;
    bq.push_back('{1'b0, 32'h0000_5000, t0 + 1});
    exp_d = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
             64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};
    rq.push_back('{1'b1, exp_i, exp_d, t0 + 5});
    wait_resp(1);
    dcache_pmem_read = 0;
    tick();

    // Reset after two beats of an I-read aborts it
    rbeat = '{64'h8888_0000_0000_0000, 64'h8888_0000_0000_0001,
              64'h8888_0000_0000_0002, 64'h8888_0000_0000_0003};
    t0 = cyc;
    icache_pmem_read = 1; icache_pmem_address = 32'h0000_6000;
    bq.push_back('{1'b0, 32'h0000_6000, t0 + 1});
    repeat (3) tick();
    rst = 1; icache_pmem_read = 0;
    exp_i = '0; exp_d = '0;
    tick();
    rst = 0; idle_probe = 1;
    tick();
    idle_probe = 0;
    t0 = cyc;
    icache_pmem_read = 1;
    bq.push_back('{1'b0, 32'h0000_6000, t0 + 1});
    exp_i = {64'h8888_0000_0000_0003, 64'h8888_0000_0000_0002,
             64'h8888_0000_0000_0001, 64'h8888_0000_0000_0000};
    rq.push_back('{1'b0, exp_i, exp_d, t0 + 5});
    wait_resp(0);
    icache_pmem_read = 0;
    tick();

    // Spurious pmem_resp while idle
    spurious = 1; idle_probe = 1;
    repeat (3) tick();
    spurious = 0;
    tick();
    idle_probe = 0;
    rbeat = '{64'h9999_0000_0000_0000, 64'h9999_0000_0000_0001,
              64'h9999_0000_0000_0002, 64'h9999_0000_0000_0003};
    t0 = cyc;
    icache_pmem_read = 1; icache_pmem_address = 32'hFFFF_FFFF;
    bq.push_back('{1'b0, 32'hFFFF_FFE0, t0 + 1});
    exp_i = {64'h9999_0000_0000_0003, 64'h9999_0000_0000_0002,
             64'h9999_0000_0000_0001, 64'h9999_0000_0000_0000};
    rq.push_back('{1'b0, exp_i, exp_d, t0 + 5});
    wait_resp(0);
    icache_pmem_read = 0;
    idle_probe = 1; tick(); idle_probe = 0;
    tick();
    done = 1;
  end
endmodule
